// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage:
//                FSM state encoding, opcode field width, the immediate-class
//                opcodes and the helper that classifies an opcode.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Width of the opcode field held in instruction[15:11].
    localparam int unsigned c_opcode_w = 5;

    // Opcodes whose instruction is followed by a 16-bit immediate word.
    localparam logic [c_opcode_w-1:0] c_op_ldm  = 5'b11000;
    localparam logic [c_opcode_w-1:0] c_op_iadd = 5'b11001;
    localparam logic [c_opcode_w-1:0] c_op_ldd  = 5'b11010;
    localparam logic [c_opcode_w-1:0] c_op_std  = 5'b11011;

    // Opcode of the no-operation instruction.
    localparam logic [c_opcode_w-1:0] c_op_nop  = 5'b00000;

    // Fetch FSM: FETCH takes a first word, IMM takes the immediate word.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        IMM   = 1'b1
    } fetch_state_e;

    // True when the opcode is one of the two-word immediate instructions.
    function automatic logic is_imm(input logic [c_opcode_w-1:0] opcode);
        return (opcode == c_op_ldm)  || (opcode == c_op_iadd) ||
               (opcode == c_op_ldd)  || (opcode == c_op_std);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_select.sv
`default_nettype none
// ============================================================================
//  Module      : pc_select
//  Description : Combinational priority mux for control-flow redirects.
//                Interrupt beats memory (RET/RTI) beats branch.
//  Ports       : branch_taken / branch_target       - branch redirect
//                pc_choose_memory / mem_pc          - stack-popped PC redirect
//                pc_choose_interrupt                - jump to INT_VECTOR
//                redirect_pc                        - selected target
//                redirect                           - any redirect requested
//  Revision    : 1.0  initial release
// ============================================================================
module pc_select #(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0002
) (
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        pc_choose_memory,
    input  logic [31:0] mem_pc,
    input  logic        pc_choose_interrupt,
    output logic [31:0] redirect_pc,
    output logic        redirect
);

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = branch_target;
        if (pc_choose_interrupt) begin
            redirect    = 1'b1;
            redirect_pc = INT_VECTOR;
        end else if (pc_choose_memory) begin
            redirect    = 1'b1;
            redirect_pc = mem_pc;
        end else if (branch_taken) begin
            redirect    = 1'b1;
            redirect_pc = branch_target;
        end
    end

endmodule : pc_select
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage and IF/ID pipeline register. Owns the
//                PC, assembles two-word immediate instructions into a single
//                IF/ID entry and applies redirects, flushes and stalls.
//  Ports       : clk, reset (sync, active-low)
//                imem_addr / imem_data              - instruction memory
//                stall_fetch, pc_write, flush_fetch - pipeline control
//                branch_*, pc_choose_*, mem_pc      - redirect sources
//                pc                                 - current PC
//                instruction, pc_plus_one_fetch,
//                ldm_value_fetch                    - IF/ID register
//                imm_pending                        - FSM is in IMM
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0002,
    parameter logic [15:0] NOP_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall_fetch,
    input  logic        pc_write,
    input  logic        flush_fetch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        pc_choose_memory,
    input  logic [31:0] mem_pc,
    input  logic        pc_choose_interrupt,
    output logic [31:0] pc,
    output logic [15:0] instruction,
    output logic [31:0] pc_plus_one_fetch,
    output logic [15:0] ldm_value_fetch,
    output logic        imm_pending
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  pending_q, pending_d;
    logic [15:0]  instr_q, instr_d;
    logic [31:0]  ppo_q, ppo_d;
    logic [15:0]  ldm_q, ldm_d;
    logic         imm_pending_q, imm_pending_d;

    logic [31:0]           w_redirect_pc;
    logic                  w_redirect;
    logic [31:0]           w_pc_inc;
    logic [c_opcode_w-1:0] w_opcode;

    pc_select #(
        .INT_VECTOR (INT_VECTOR)
    ) u_pc_select (
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .pc_choose_memory    (pc_choose_memory),
        .mem_pc              (mem_pc),
        .pc_choose_interrupt (pc_choose_interrupt),
        .redirect_pc         (w_redirect_pc),
        .redirect            (w_redirect)
    );

    // Modulo-2^32 increment: 32'hFFFF_FFFF wraps to 0 silently.
    assign w_pc_inc = pc_q + 32'd1;
    assign w_opcode = imem_data[15:11];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        instr_d   = instr_q;
        ppo_d     = ppo_q;
        ldm_d     = ldm_q;

        if (w_redirect) begin
            // Redirect wins over stall and pc_write so control flow is never lost.
            pc_d      = w_redirect_pc;
            instr_d   = NOP_WORD;
            state_d   = FETCH;
            pending_d = NOP_WORD;
        end else if (flush_fetch) begin
            instr_d   = NOP_WORD;
            state_d   = FETCH;
            pending_d = NOP_WORD;
        end else if (stall_fetch) begin
            // Everything holds.
        end else if (!pc_write) begin
            instr_d = NOP_WORD;
        end else begin
            case (state_q)
                FETCH: begin
                    pc_d = w_pc_inc;
                    if (is_imm(w_opcode)) begin
                        // Park the opcode word; a bubble goes down while the
                        // immediate word is fetched.
                        pending_d = imem_data;
                        instr_d   = NOP_WORD;
                        state_d   = IMM;
                    end else begin
                        instr_d = imem_data;
                        ppo_d   = w_pc_inc;
                    end
                end
                IMM: begin
                    // The word on imem_data is raw immediate data, never decoded.
                    instr_d = pending_q;
                    ldm_d   = imem_data;
                    ppo_d   = w_pc_inc;
                    pc_d    = w_pc_inc;
                    state_d = FETCH;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Registered decode of the next state, so the flag never depends on inputs.
    assign imm_pending_d = (state_d == IMM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            pending_q     <= 16'h0000;
            instr_q       <= NOP_WORD;
            ppo_q         <= 32'h0000_0000;
            ldm_q         <= 16'h0000;
            imm_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            instr_q       <= instr_d;
            ppo_q         <= ppo_d;
            ldm_q         <= ldm_d;
            imm_pending_q <= imm_pending_d;
        end
    end

    assign imem_addr         = pc_q;
    assign pc                = pc_q;
    assign instruction       = instr_q;
    assign pc_plus_one_fetch = ppo_q;
    assign ldm_value_fetch   = ldm_q;
    assign imm_pending       = imm_pending_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall_fetch;
    logic        pc_write;
    logic        flush_fetch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        pc_choose_memory;
    logic [31:0] mem_pc;
    logic        pc_choose_interrupt;
    logic [31:0] pc;
    logic [15:0] instruction;
    logic [31:0] pc_plus_one_fetch;
    logic [15:0] ldm_value_fetch;
    logic        imm_pending;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    // Combinational instruction memory, indexed by the low address byte.
    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_addr           (imem_addr),
        .imem_data           (imem_data),
        .stall_fetch         (stall_fetch),
        .pc_write            (pc_write),
        .flush_fetch         (flush_fetch),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .pc_choose_memory    (pc_choose_memory),
        .mem_pc              (mem_pc),
        .pc_choose_interrupt (pc_choose_interrupt),
        .pc                  (pc),
        .instruction         (instruction),
        .pc_plus_one_fetch   (pc_plus_one_fetch),
        .ldm_value_fetch     (ldm_value_fetch),
        .imm_pending         (imm_pending)
    );

    // Advance one edge and settle; inputs are changed right after this.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL rst_instr got=%h exp=%h", instruction, 16'h0); end
        checks++; if (pc_plus_one_fetch !== 32'h0) begin errors++; $display("FAIL rst_ppo got=%h exp=%h", pc_plus_one_fetch, 32'h0); end
        checks++; if (ldm_value_fetch !== 16'h0) begin errors++; $display("FAIL rst_ldm got=%h exp=%h", ldm_value_fetch, 16'h0); end
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL rst_pend got=%b exp=0", imm_pending); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        step();
        checks++; if (instruction !== 16'h0800) begin errors++; $display("FAIL seq1_instr got=%h exp=%h", instruction, 16'h0800); end
        checks++; if (pc_plus_one_fetch !== 32'd1) begin errors++; $display("FAIL seq1_ppo got=%h exp=%h", pc_plus_one_fetch, 32'd1); end
        step();
        checks++; if (instruction !== 16'h1000) begin errors++; $display("FAIL seq2_instr got=%h exp=%h", instruction, 16'h1000); end
        checks++; if (pc_plus_one_fetch !== 32'd2) begin errors++; $display("FAIL seq2_ppo got=%h exp=%h", pc_plus_one_fetch, 32'd2); end
        checks++; if (pc !== 32'd2) begin errors++; $display("FAIL seq2_pc got=%h exp=%h", pc, 32'd2); end
        step();
        step();
        checks++; if (pc !== 32'd4) begin errors++; $display("FAIL seq4_pc got=%h exp=%h", pc, 32'd4); end
    endtask

    task automatic test_ldm();
        step();
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL ldm1_instr got=%h exp=%h", instruction, 16'h0); end
        checks++; if (imm_pending !== 1'b1) begin errors++; $display("FAIL ldm1_pend got=%b exp=1", imm_pending); end
        checks++; if (pc !== 32'd5) begin errors++; $display("FAIL ldm1_pc got=%h exp=%h", pc, 32'd5); end
        step();
        checks++; if (instruction !== 16'hC100) begin errors++; $display("FAIL ldm2_instr got=%h exp=%h", instruction, 16'hC100); end
        checks++; if (ldm_value_fetch !== 16'hBEEF) begin errors++; $display("FAIL ldm2_ldm got=%h exp=%h", ldm_value_fetch, 16'hBEEF); end
        checks++; if (pc_plus_one_fetch !== 32'd6) begin errors++; $display("FAIL ldm2_ppo got=%h exp=%h", pc_plus_one_fetch, 32'd6); end
        checks++; if (pc !== 32'd6) begin errors++; $display("FAIL ldm2_pc got=%h exp=%h", pc, 32'd6); end
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL ldm2_pend got=%b exp=0", imm_pending); end
    endtask

    task automatic test_stall_imm();
        step();   // IADD opcode word at 6 is parked
        checks++; if (imm_pending !== 1'b1) begin errors++; $display("FAIL stl_enter_pend got=%b exp=1", imm_pending); end
        stall_fetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'd7) begin errors++; $display("FAIL stl_pc[%0d] got=%h exp=%h", i, pc, 32'd7); end
            checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL stl_instr[%0d] got=%h exp=%h", i, instruction, 16'h0); end
            checks++; if (imm_pending !== 1'b1) begin errors++; $display("FAIL stl_pend[%0d] got=%b exp=1", i, imm_pending); end
        end
        stall_fetch = 1'b0;
        step();
        checks++; if (instruction !== 16'hC8AB) begin errors++; $display("FAIL stl_done_instr got=%h exp=%h", instruction, 16'hC8AB); end
        checks++; if (ldm_value_fetch !== 16'h1234) begin errors++; $display("FAIL stl_done_ldm got=%h exp=%h", ldm_value_fetch, 16'h1234); end
        checks++; if (pc_plus_one_fetch !== 32'd8) begin errors++; $display("FAIL stl_done_ppo got=%h exp=%h", pc_plus_one_fetch, 32'd8); end
        checks++; if (pc !== 32'd8) begin errors++; $display("FAIL stl_done_pc got=%h exp=%h", pc, 32'd8); end
    endtask

    task automatic test_pc_write();
        pc_write = 1'b0;
        step();
        checks++; if (pc !== 32'd8) begin errors++; $display("FAIL pcw_pc got=%h exp=%h", pc, 32'd8); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL pcw_instr got=%h exp=%h", instruction, 16'h0); end
        checks++; if (pc_plus_one_fetch !== 32'd8) begin errors++; $display("FAIL pcw_ppo got=%h exp=%h", pc_plus_one_fetch, 32'd8); end
        checks++; if (ldm_value_fetch !== 16'h1234) begin errors++; $display("FAIL pcw_ldm got=%h exp=%h", ldm_value_fetch, 16'h1234); end
        pc_write = 1'b1;
        step();
        checks++; if (instruction !== 16'h2000) begin errors++; $display("FAIL pcw_rel_instr got=%h exp=%h", instruction, 16'h2000); end
        checks++; if (pc !== 32'd9) begin errors++; $display("FAIL pcw_rel_pc got=%h exp=%h", pc, 32'd9); end
    endtask

    task automatic test_flush();
        step();   // LDD opcode word at 9 enters IMM
        checks++; if (imm_pending !== 1'b1) begin errors++; $display("FAIL fl_pend got=%b exp=1", imm_pending); end
        flush_fetch = 1'b1;
        step();
        flush_fetch = 1'b0;
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL fl_drop got=%b exp=0", imm_pending); end
        checks++; if (pc !== 32'd10) begin errors++; $display("FAIL fl_pc got=%h exp=%h", pc, 32'd10); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL fl_instr got=%h exp=%h", instruction, 16'h0); end
        step();
        checks++; if (instruction !== 16'h3000) begin errors++; $display("FAIL fl_next_instr got=%h exp=%h", instruction, 16'h3000); end
        checks++; if (pc_plus_one_fetch !== 32'd11) begin errors++; $display("FAIL fl_next_ppo got=%h exp=%h", pc_plus_one_fetch, 32'd11); end
    endtask

    task automatic test_redirects();
        // Branch overrides a simultaneous stall.
        branch_taken = 1'b1; branch_target = 32'h40; stall_fetch = 1'b1;
        step();
        branch_taken = 1'b0; stall_fetch = 1'b0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_pc got=%h exp=%h", pc, 32'h40); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL br_instr got=%h exp=%h", instruction, 16'h0); end
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL br_pend got=%b exp=0", imm_pending); end
        step();   // STD word at 0x40 enters IMM
        checks++; if (imm_pending !== 1'b1) begin errors++; $display("FAIL mem_pre_pend got=%b exp=1", imm_pending); end
        // Memory beats branch, and the pending word is dropped.
        pc_choose_memory = 1'b1; mem_pc = 32'h80; branch_taken = 1'b1; branch_target = 32'h50;
        step();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL mem_pc got=%h exp=%h", pc, 32'h80); end
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL mem_pend got=%b exp=0", imm_pending); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL mem_instr got=%h exp=%h", instruction, 16'h0); end
        // Interrupt beats everything, even with pc_write low.
        pc_choose_interrupt = 1'b1; pc_write = 1'b0;
        step();
        pc_choose_interrupt = 1'b0; pc_choose_memory = 1'b0; branch_taken = 1'b0; pc_write = 1'b1;
        checks++; if (pc !== 32'd2) begin errors++; $display("FAIL int_pc got=%h exp=%h", pc, 32'd2); end
    endtask

    task automatic test_wrap_and_reset_in_imm();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wr_pre_pc got=%h exp=%h", pc, 32'hFFFF_FFFF); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wr_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (pc_plus_one_fetch !== 32'h0) begin errors++; $display("FAIL wr_ppo got=%h exp=%h", pc_plus_one_fetch, 32'h0); end
        checks++; if (instruction !== 16'h0801) begin errors++; $display("FAIL wr_instr got=%h exp=%h", instruction, 16'h0801); end
        branch_taken = 1'b1; branch_target = 32'd4;
        step();
        branch_taken = 1'b0;
        step();   // LDM at 4 enters IMM
        checks++; if (imm_pending !== 1'b1) begin errors++; $display("FAIL rimm_pre got=%b exp=1", imm_pending); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rimm_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (imm_pending !== 1'b0) begin errors++; $display("FAIL rimm_pend got=%b exp=0", imm_pending); end
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL rimm_instr got=%h exp=%h", instruction, 16'h0); end
        checks++; if (ldm_value_fetch !== 16'h0) begin errors++; $display("FAIL rimm_ldm got=%h exp=%h", ldm_value_fetch, 16'h0); end
        step();   // pending C100 must not reappear
        checks++; if (instruction !== 16'h0800) begin errors++; $display("FAIL rimm_next got=%h exp=%h", instruction, 16'h0800); end
        checks++; if (pc !== 32'd1) begin errors++; $display("FAIL rimm_next_pc got=%h exp=%h", pc, 32'd1); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0801;
        mem[0]    = 16'h0800;
        mem[1]    = 16'h1000;
        mem[2]    = 16'h0801;
        mem[3]    = 16'h0802;
        mem[4]    = 16'hC100;   // LDM
        mem[5]    = 16'hBEEF;
        mem[6]    = 16'hC8AB;   // IADD
        mem[7]    = 16'h1234;
        mem[8]    = 16'h2000;
        mem[9]    = 16'hD000;   // LDD
        mem[10]   = 16'h3000;
        mem[8'h40] = 16'hD8FF;  // STD
        mem[8'hFF] = 16'h0801;

        reset               = 1'b0;
        stall_fetch         = 1'b0;
        pc_write            = 1'b1;
        flush_fetch         = 1'b0;
        branch_taken        = 1'b0;
        branch_target       = 32'h0;
        pc_choose_memory    = 1'b0;
        mem_pc              = 32'h0;
        pc_choose_interrupt = 1'b0;

        test_reset();
        test_sequential();
        test_ldm();
        test_stall_imm();
        test_pc_write();
        test_flush();
        test_redirects();
        test_wrap_and_reset_in_imm();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
